// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned MD_LATENCY_DEF  = 4;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;
    localparam int unsigned MD_CNT_W        = 8;
    localparam int unsigned WAIT_CNT_W      = 16;
    localparam int unsigned STALL_CNT_W     = 32;
    localparam int unsigned REG_ADDR_W      = 5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Register enables and bubble inserts for every pipeline boundary
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_DEFAULT = '{
        pc_write:     1'b1,
        if_id_write:  1'b1,
        id_ex_write:  1'b1,
        ex_mem_write: 1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0,
        mem_wb_flush: 1'b0
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard status from the pipeline stages and the enables/flushes sent back.
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0]  rs1Addr_id;
    logic [REG_ADDR_W-1:0]  rs2Addr_id;
    logic                   use_rs1_id;
    logic                   use_rs2_id;
    logic                   MemRead_ex;
    logic [REG_ADDR_W-1:0]  rdAddr_ex;
    logic                   branch_taken_ex;
    logic                   md_op_ex;
    logic                   dmem_req_mem;
    logic                   dmem_ready;
    logic                   pc_write;
    logic                   if_id_write;
    logic                   id_ex_write;
    logic                   ex_mem_write;
    logic                   if_id_flush;
    logic                   id_ex_flush;
    logic                   ex_mem_flush;
    logic                   mem_wb_flush;
    logic                   md_busy;
    logic                   bus_err;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Pipeline side
    modport master (
        output rs1Addr_id, rs2Addr_id, use_rs1_id, use_rs2_id, MemRead_ex, rdAddr_ex,
               branch_taken_ex, md_op_ex, dmem_req_mem, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
               id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy, bus_err, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  rs1Addr_id, rs2Addr_id, use_rs1_id, use_rs2_id, MemRead_ex, rdAddr_ex,
               branch_taken_ex, md_op_ex, dmem_req_mem, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
               id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy, bus_err, stall_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read_ex_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_ex_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_id_i,
    input  logic                  use_rs1_id_i,
    input  logic                  use_rs2_id_i,
    output logic                  load_use_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c  = use_rs1_id_i && (rd_addr_ex_i == rs1_addr_id_i);
    assign rs2_hit_c  = use_rs2_id_i && (rd_addr_ex_i == rs2_addr_id_i);
    assign load_use_c = mem_read_ex_i && (rd_addr_ex_i != '0) && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch, multi-cycle mul/div and dmem wait states.
// Enables/flushes are combinational; md_busy, bus_err and stall_cnt come from registers.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY  = MD_LATENCY_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [MD_CNT_W-1:0]   MD_INIT   = MD_CNT_W'(MD_LATENCY - 2);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    md_state_e               state_q,     state_d;
    logic [MD_CNT_W-1:0]     md_cnt_q,    md_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic                    bus_err_q,   bus_err_d;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic       mem_wait_c;
    logic       load_use_c;
    logic       md_freeze_c;
    pipe_ctrl_t ctrl_c;

    assign mem_wait_c = hz.dmem_req_mem && !hz.dmem_ready;

    load_use_detect u_load_use_detect (
        .mem_read_ex_i (hz.MemRead_ex),
        .rd_addr_ex_i  (hz.rdAddr_ex),
        .rs1_addr_id_i (hz.rs1Addr_id),
        .rs2_addr_id_i (hz.rs2Addr_id),
        .use_rs1_id_i  (hz.use_rs1_id),
        .use_rs2_id_i  (hz.use_rs2_id),
        .load_use_c    (load_use_c)
    );

    // Mul/div occupancy: a dmem wait stalls the countdown and delays the release
    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        md_freeze_c = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (hz.md_op_ex && !mem_wait_c) begin
                    md_freeze_c = 1'b1;
                    state_d     = MD_BUSY;
                    md_cnt_d    = MD_INIT;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q != '0) begin
                    md_freeze_c = 1'b1;
                    if (!mem_wait_c) begin
                        md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                    end
                end else if (!mem_wait_c) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // One priority level per cycle: wait, freeze, branch squash, load-use bubble
    always_comb begin
        ctrl_c = CTRL_DEFAULT;
        if (mem_wait_c) begin
            ctrl_c.pc_write     = 1'b0;
            ctrl_c.if_id_write  = 1'b0;
            ctrl_c.id_ex_write  = 1'b0;
            ctrl_c.ex_mem_write = 1'b0;
            ctrl_c.mem_wb_flush = 1'b1;
        end else if (md_freeze_c) begin
            ctrl_c.pc_write     = 1'b0;
            ctrl_c.if_id_write  = 1'b0;
            ctrl_c.id_ex_write  = 1'b0;
            ctrl_c.ex_mem_flush = 1'b1;
        end else if (hz.branch_taken_ex) begin
            ctrl_c.if_id_flush  = 1'b1;
            ctrl_c.id_ex_flush  = 1'b1;
        end else if (load_use_c) begin
            ctrl_c.pc_write     = 1'b0;
            ctrl_c.if_id_write  = 1'b0;
            ctrl_c.id_ex_flush  = 1'b1;
        end
    end

    // Timeout watchdog and saturating stall statistics
    always_comb begin
        wait_cnt_d  = '0;
        bus_err_d   = bus_err_q;
        stall_cnt_d = stall_cnt_q;
        if (mem_wait_c) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
            if (wait_cnt_q == WAIT_LAST) begin
                bus_err_d = 1'b1;
            end
        end
        if (!ctrl_c.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= MD_IDLE;
            md_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_write     = ctrl_c.pc_write;
    assign hz.if_id_write  = ctrl_c.if_id_write;
    assign hz.id_ex_write  = ctrl_c.id_ex_write;
    assign hz.ex_mem_write = ctrl_c.ex_mem_write;
    assign hz.if_id_flush  = ctrl_c.if_id_flush;
    assign hz.id_ex_flush  = ctrl_c.id_ex_flush;
    assign hz.ex_mem_flush = ctrl_c.ex_mem_flush;
    assign hz.mem_wb_flush = ctrl_c.mem_wb_flush;
    assign hz.md_busy      = (state_q == MD_BUSY);
    assign hz.bus_err      = bus_err_q;
    assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LATENCY=4, MEM_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_RUN   = 8'b1111_0000;
    localparam logic [7:0] C_LU    = 8'b0011_0100;
    localparam logic [7:0] C_MD    = 8'b0001_0010;
    localparam logic [7:0] C_WAIT  = 8'b0000_0001;
    localparam logic [7:0] C_BR    = 8'b1111_1100;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_pass;
    int   exp_stall;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MD_LATENCY  (4),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz)
    );

    logic [7:0] ctl;
    assign ctl = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                  hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs1Addr_id      = 5'd0;
        hz.rs2Addr_id      = 5'd0;
        hz.use_rs1_id      = 1'b0;
        hz.use_rs2_id      = 1'b0;
        hz.MemRead_ex      = 1'b0;
        hz.rdAddr_ex       = 5'd0;
        hz.branch_taken_ex = 1'b0;
        hz.md_op_ex        = 1'b0;
        hz.dmem_req_mem    = 1'b0;
        hz.dmem_ready      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_RUN) $display("FAIL reset_ctl got %b want %b", ctl, C_RUN); else n_pass++;
        n_chk++;
        if ({hz.md_busy, hz.bus_err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {hz.md_busy, hz.bus_err}); else n_pass++;
        n_chk++;
        if (hz.stall_cnt !== 32'd0) $display("FAIL reset_stall got %0d want 0", hz.stall_cnt); else n_pass++;
        tick();
        rstn = 1'b1;
        tick();
        exp_stall = 0;
    endtask

    task automatic test_load_use();
        hz.MemRead_ex = 1'b1; hz.rdAddr_ex = 5'd5;
        hz.rs1Addr_id = 5'd3; hz.use_rs1_id = 1'b1;
        hz.rs2Addr_id = 5'd5; hz.use_rs2_id = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_LU) $display("FAIL load_use_rs2 got %b want %b", ctl, C_LU); else n_pass++;
        exp_stall++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (ctl !== C_RUN) $display("FAIL load_use_release got %b want %b", ctl, C_RUN); else n_pass++;
        n_chk++;
        if (hz.stall_cnt !== 32'(exp_stall)) $display("FAIL load_use_stall got %0d want %0d", hz.stall_cnt, exp_stall); else n_pass++;
        // rs1 match is also a hazard
        tick();
        hz.MemRead_ex = 1'b1; hz.rdAddr_ex = 5'd12;
        hz.rs1Addr_id = 5'd12; hz.use_rs1_id = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_LU) $display("FAIL load_use_rs1 got %b want %b", ctl, C_LU); else n_pass++;
        exp_stall++;
        tick();
        idle_inputs();
    endtask

    task automatic test_no_stall();
        hz.MemRead_ex = 1'b1; hz.rdAddr_ex = 5'd0;
        hz.rs2Addr_id = 5'd0; hz.use_rs2_id = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_RUN) $display("FAIL no_stall_x0 got %b want %b", ctl, C_RUN); else n_pass++;
        tick();
        hz.rdAddr_ex = 5'd5; hz.rs2Addr_id = 5'd5; hz.use_rs2_id = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_RUN) $display("FAIL no_stall_unused got %b want %b", ctl, C_RUN); else n_pass++;
        tick();
        hz.use_rs2_id = 1'b1; hz.MemRead_ex = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_RUN) $display("FAIL no_stall_notload got %b want %b", ctl, C_RUN); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (hz.stall_cnt !== 32'(exp_stall)) $display("FAIL no_stall_cnt got %0d want %0d", hz.stall_cnt, exp_stall); else n_pass++;
        tick();
    endtask

    task automatic test_muldiv();
        logic [7:0] exp_ctl [4] = '{C_MD, C_MD, C_MD, C_RUN};
        logic       exp_busy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        hz.md_op_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({ctl, hz.md_busy} !== {exp_ctl[i], exp_busy[i]})
                $display("FAIL muldiv_c%0d got %b/%b want %b/%b", i, ctl, hz.md_busy, exp_ctl[i], exp_busy[i]);
            else n_pass++;
            tick();
        end
        exp_stall += 3;
        hz.md_op_ex = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({hz.md_busy, hz.stall_cnt} !== {1'b0, 32'(exp_stall)})
            $display("FAIL muldiv_done got busy=%b stall=%0d want busy=0 stall=%0d", hz.md_busy, hz.stall_cnt, exp_stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ctl [8] = '{C_MD, C_MD, C_MD, C_RUN, C_MD, C_MD, C_MD, C_RUN};
        hz.md_op_ex = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (ctl !== exp_ctl[i]) $display("FAIL b2b_c%0d got %b want %b", i, ctl, exp_ctl[i]); else n_pass++;
            tick();
        end
        exp_stall += 6;
        hz.md_op_ex = 1'b0;
        tick();
    endtask

    task automatic test_md_mem_wait();
        logic [7:0] exp_ctl [6] = '{C_MD, C_WAIT, C_WAIT, C_MD, C_MD, C_RUN};
        logic       wait_on [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        hz.md_op_ex = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hz.dmem_req_mem = wait_on[i];
            hz.dmem_ready   = 1'b0;
            @(negedge clk);
            n_chk++;
            if (ctl !== exp_ctl[i]) $display("FAIL md_wait_c%0d got %b want %b", i, ctl, exp_ctl[i]); else n_pass++;
            tick();
        end
        exp_stall += 5;
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if ({hz.md_busy, hz.bus_err, hz.stall_cnt} !== {2'b00, 32'(exp_stall)})
            $display("FAIL md_wait_done got busy=%b err=%b stall=%0d want 0/0/%0d", hz.md_busy, hz.bus_err, hz.stall_cnt, exp_stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch();
        hz.MemRead_ex = 1'b1; hz.rdAddr_ex = 5'd7;
        hz.rs1Addr_id = 5'd7; hz.use_rs1_id = 1'b1;
        hz.branch_taken_ex = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_BR) $display("FAIL branch_over_lu got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        hz.dmem_req_mem = 1'b1; hz.dmem_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_WAIT) $display("FAIL branch_wait got %b want %b", ctl, C_WAIT); else n_pass++;
        exp_stall++;
        tick();
        hz.dmem_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== C_BR) $display("FAIL branch_after_wait got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if (hz.stall_cnt !== 32'(exp_stall)) $display("FAIL branch_stall got %0d want %0d", hz.stall_cnt, exp_stall); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        hz.dmem_req_mem = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if ({ctl, hz.bus_err} !== {C_WAIT, 1'b0})
                $display("FAIL timeout_w%0d got %b/%b want %b/0", i, ctl, hz.bus_err, C_WAIT);
            else n_pass++;
            tick();
        end
        exp_stall += 8;
        hz.dmem_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({ctl, hz.bus_err} !== {C_RUN, 1'b1}) $display("FAIL timeout_set got %b/%b want %b/1", ctl, hz.bus_err, C_RUN); else n_pass++;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_chk++;
        if ({hz.bus_err, hz.stall_cnt} !== {1'b1, 32'(exp_stall)})
            $display("FAIL timeout_sticky got err=%b stall=%0d want 1/%0d", hz.bus_err, hz.stall_cnt, exp_stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        hz.md_op_ex = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_chk++;
        if (hz.md_busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", hz.md_busy); else n_pass++;
        #1;
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({hz.md_busy, hz.bus_err, hz.stall_cnt} !== {2'b00, 32'd0})
            $display("FAIL rst_async got busy=%b err=%b stall=%0d want 0/0/0", hz.md_busy, hz.bus_err, hz.stall_cnt);
        else n_pass++;
        idle_inputs();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({ctl, hz.md_busy} !== {C_RUN, 1'b0}) $display("FAIL rst_after got %b/%b want %b/0", ctl, hz.md_busy, C_RUN); else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_stall = 0;
        rstn = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_muldiv();
        test_back_to_back();
        test_md_mem_wait();
        test_branch();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
